// File: rtl/spi_regmap_pkg.sv
// rtl/spi_regmap_pkg.sv - shared frame geometry, opcodes and register-map constants
package spi_regmap_pkg;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_FRAME_W = 1 + SPI_ADDR_W + SPI_DATA_W;

  localparam logic SPI_RD = 1'b1;
  localparam logic SPI_WR = 1'b0;

  localparam int NUM_CONFIG_REG = 96;
  localparam int NUM_STATUS_REG = 32;

  localparam logic [7:0] STATUS_FILL_LO = 8'h00;
  localparam logic [7:0] STATUS_FILL_HI = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_TRAIL,
    ST_GAP
  } spi_state_e;

  // Status block: lower half reads 0x00, upper half reads 0xFF
  function automatic logic [7:0] status_fill(input logic [6:0] addr);
    return (addr >= 7'd112) ? STATUS_FILL_HI : STATUS_FILL_LO;
  endfunction
endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK half-period counter with rise/fall tick strobes
module spi_sck_gen #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sck_level,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  always_comb begin
    tick = en && (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q;
    if (clr || !en || tick) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
    // The current SCK level decides which edge this tick produces
    rise_tick = tick && !sck_level;
    fall_tick = tick && sck_level;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_regmap_master.sv
// rtl/spi_regmap_master.sv - SPI mode-0 master issuing single-register read/write frames
module spi_regmap_master
  import spi_regmap_pkg::*;
#(
  parameter int ADDR_WIDTH = SPI_ADDR_W,
  parameter int DATA_WIDTH = SPI_DATA_W,
  parameter int CLK_DIV    = 5,
  parameter int CS_GAP     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_sck,
  output logic                  spi_cs_n,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  localparam int F   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int FCW = $clog2(F);
  localparam int GCW = $clog2(CS_GAP + 1);

  spi_state_e            state_q, state_d;
  logic [F-1:0]          tx_q, tx_d, rx_q, rx_d, frame;
  logic [FCW-1:0]        fall_cnt_q, fall_cnt_d;
  logic [GCW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                  sck_q, sck_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic                  cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  handshake, sck_en, rise_tick, fall_tick;

  assign handshake = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign sck_en    = (state_q == ST_SHIFT) || (state_q == ST_TRAIL);
  assign frame     = {cmd_rw, cmd_addr, (cmd_rw == SPI_RD) ? {DATA_WIDTH{1'b0}} : cmd_wdata};

  spi_sck_gen #(.DIV(CLK_DIV)) u_sck_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (handshake),
    .en        (sck_en),
    .sck_level (sck_q),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    fall_cnt_d  = fall_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          state_d     = ST_SHIFT;
          cs_n_d      = 1'b0;
          mosi_d      = frame[F-1];
          tx_d        = frame << 1;
          fall_cnt_d  = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise_tick) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[F-2:0], spi_miso};
        end
        // tx_q runs out of ones after F shifts, so MOSI returns to 0 on the last fall
        if (fall_tick) begin
          sck_d  = 1'b0;
          mosi_d = tx_q[F-1];
          tx_d   = tx_q << 1;
          if (fall_cnt_q == FCW'(F - 1)) state_d = ST_TRAIL;
          else fall_cnt_d = fall_cnt_q + 1'b1;
        end
      end
      ST_TRAIL: begin
        if (rise_tick) begin
          state_d     = ST_GAP;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q[DATA_WIDTH-1:0];
          gap_cnt_d   = '0;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GCW'(CS_GAP - 1)) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      fall_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      fall_cnt_q  <= fall_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign spi_sck   = sck_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;
endmodule

// File: tb/tb_spi_regmap_master.sv
// tb/tb_spi_regmap_master.sv - directed bench with register-map slave model, CLK_DIV 5/4/8
module tb_spi_regmap_master;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       spi_miso = 1'b0;
  int         sel = 0;

  logic       vld_w [3];
  logic       rdy_w [3];
  logic       rspv_w [3];
  logic [7:0] rdat_w [3];
  logic       busy_w [3];
  logic       sck_w [3];
  logic       cs_w [3];
  logic       mosi_w [3];

  logic       rdy_m, rspv_m, busy_m, sck_m, cs_m, mosi_m;
  logic [7:0] rdat_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_regmap_master #(.CLK_DIV(5)) u_dut_d5 (
    .clk(clk), .rst(rst), .cmd_valid(vld_w[0]), .cmd_ready(rdy_w[0]), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rspv_w[0]), .rsp_rdata(rdat_w[0]),
    .busy(busy_w[0]), .spi_sck(sck_w[0]), .spi_cs_n(cs_w[0]), .spi_mosi(mosi_w[0]), .spi_miso(spi_miso));
  spi_regmap_master #(.CLK_DIV(4)) u_dut_d4 (
    .clk(clk), .rst(rst), .cmd_valid(vld_w[1]), .cmd_ready(rdy_w[1]), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rspv_w[1]), .rsp_rdata(rdat_w[1]),
    .busy(busy_w[1]), .spi_sck(sck_w[1]), .spi_cs_n(cs_w[1]), .spi_mosi(mosi_w[1]), .spi_miso(spi_miso));
  spi_regmap_master #(.CLK_DIV(8)) u_dut_d8 (
    .clk(clk), .rst(rst), .cmd_valid(vld_w[2]), .cmd_ready(rdy_w[2]), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rspv_w[2]), .rsp_rdata(rdat_w[2]),
    .busy(busy_w[2]), .spi_sck(sck_w[2]), .spi_cs_n(cs_w[2]), .spi_mosi(mosi_w[2]), .spi_miso(spi_miso));

  always_comb begin
    for (int i = 0; i < 3; i++) vld_w[i] = cmd_valid && (sel == i);
    rdy_m  = rdy_w[sel];
    rspv_m = rspv_w[sel];
    rdat_m = rdat_w[sel];
    busy_m = busy_w[sel];
    sck_m  = sck_w[sel];
    cs_m   = cs_w[sel];
    mosi_m = mosi_w[sel];
  end

  // Register-map slave model: oversamples SCK, shifts MISO out on falling edges
  logic [7:0]  regs [128];
  logic [15:0] s_rx = '0;
  logic [15:0] last_frame = '0;
  logic [7:0]  s_out = '0;
  int          s_cnt = 0;
  logic        s_cs_prev = 1'b1, s_sck_prev = 1'b0;

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'h00;
    regs[3] = 8'h3C;
  end

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a < 7'd96) return regs[a];
    else if (a < 7'd112) return 8'h00;
    else return 8'hFF;
  endfunction

  always @(negedge clk) begin
    if (cs_m) begin
      if (!s_cs_prev && s_cnt == 16) begin
        last_frame = s_rx;
        if (!s_rx[15] && s_rx[14:8] < 7'd96) regs[s_rx[14:8]] = s_rx[7:0];
      end
      s_cnt = 0;
      spi_miso = 1'b0;
    end else if (sck_m && !s_sck_prev) begin
      s_rx = {s_rx[14:0], mosi_m};
      s_cnt++;
      if (s_cnt == 8) s_out = s_rx[7] ? model_read(s_rx[6:0]) : 8'h00;
    end else if (!sck_m && s_sck_prev) begin
      if (s_cnt >= 8 && s_cnt < 16) begin
        spi_miso = s_out[7];
        s_out = {s_out[6:0], 1'b0};
      end else spi_miso = 1'b0;
    end
    s_cs_prev = cs_m;
    s_sck_prev = sck_m;
  end

  // Bus monitor: CS low/high run lengths, response timing and order
  int cyc = 0, e0_cyc = 0, rsp_cyc = 0, rsp_n = 0;
  int low_run = 0, high_run = 0, last_low = 0;
  int gaps [$];
  logic [7:0] rsp_q [$];
  logic m_cs_prev = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!cs_m && m_cs_prev) begin
      e0_cyc = cyc;
      gaps.push_back(high_run);
      low_run = 0;
    end
    if (cs_m && !m_cs_prev) begin
      last_low = low_run;
      high_run = 0;
    end
    if (cs_m) high_run++;
    else low_run++;
    if (rspv_m) begin
      rsp_n++;
      rsp_cyc = cyc;
      rsp_q.push_back(rdat_m);
    end
    m_cs_prev = cs_m;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (rdy_m) ok = 1;
      else @(negedge clk);
    end
    if (!ok) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic do_cmd(input int s, input logic rw, input logic [6:0] a, input logic [7:0] d,
                        output logic [7:0] rd);
    bit ok = 0;
    sel = s;
    @(negedge clk);
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    wait_ready("cmd");
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rd = 8'hxx;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (rspv_m) begin
        ok = 1;
        rd = rdat_m;
      end else @(negedge clk);
    end
    if (!ok) check("rsp_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] rd;
  logic [6:0] b2b_addr [3];
  int n0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs_n", cs_m, 1);
    check("rst_sck", sck_m, 0);
    check("rst_mosi", mosi_m, 0);
    check("rst_cmd_ready", rdy_m, 1);
    check("rst_rsp_valid", rspv_m, 0);
    check("rst_rsp_rdata", rdat_m, 8'h00);
    check("rst_busy", busy_m, 0);

    n0 = rsp_n;
    do_cmd(0, 1'b0, 7'h05, 8'hA5, rd);
    check("wr_frame", last_frame, 16'h05A5);
    check("wr_cs_low", last_low, 165);
    check("wr_rsp_delay", rsp_cyc - e0_cyc, 165);
    repeat (20) @(negedge clk);
    check("wr_rsp_count", rsp_n - n0, 1);

    do_cmd(0, 1'b1, 7'h03, 8'hFF, rd);
    check("rd03_data", rd, 8'h3C);
    check("rd03_frame", last_frame, 16'h8300);

    do_cmd(0, 1'b0, 7'h0A, 8'h5A, rd);
    do_cmd(0, 1'b1, 7'h0A, 8'h00, rd);
    check("rd0a_data", rd, 8'h5A);
    do_cmd(0, 1'b1, 7'h60, 8'h00, rd);
    check("rd60_data", rd, 8'h00);
    do_cmd(0, 1'b1, 7'h70, 8'h00, rd);
    check("rd70_data", rd, 8'hFF);
    do_cmd(0, 1'b1, 7'h00, 8'h00, rd);
    check("rd00_data", rd, 8'h00);

    // Three reads with cmd_valid held high throughout
    b2b_addr[0] = 7'h03; b2b_addr[1] = 7'h0A; b2b_addr[2] = 7'h70;
    sel = 0;
    rsp_q.delete();
    gaps.delete();
    n0 = rsp_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_addr = b2b_addr[k];
      wait_ready("b2b");
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 2000 && rsp_q.size() < 3; i++) @(posedge clk);
    repeat (20) @(negedge clk);
    check("b2b_rsp_count", rsp_n - n0, 3);
    if (rsp_q.size() == 3 && gaps.size() == 3) begin
      check("b2b_rd0", rsp_q[0], 8'h3C);
      check("b2b_rd1", rsp_q[1], 8'h5A);
      check("b2b_rd2", rsp_q[2], 8'hFF);
      check("b2b_gap1", gaps[1], 11);
      check("b2b_gap2", gaps[2], 11);
    end else check("b2b_queue_size", rsp_q.size() * 16 + gaps.size(), 3 * 16 + 3);

    // Reset 40 cycles into a write frame
    sel = 0;
    n0 = rsp_n;
    @(negedge clk);
    cmd_rw = 1'b0; cmd_addr = 7'h0B; cmd_wdata = 8'h77; cmd_valid = 1'b1;
    wait_ready("rst_mid");
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (38) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", cs_m, 1);
    check("midrst_sck", sck_m, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("midrst_no_rsp", rsp_n - n0, 0);
    check("midrst_rdata", rdat_m, 8'h00);
    do_cmd(0, 1'b1, 7'h0B, 8'h00, rd);
    check("midrst_rd0b", rd, 8'h00);
    do_cmd(0, 1'b1, 7'h0A, 8'h00, rd);
    check("midrst_rd0a", rd, 8'h5A);

    // CLK_DIV sweep
    do_cmd(1, 1'b0, 7'h20, 8'hC3, rd);
    check("div4_wr_cs_low", last_low, 132);
    do_cmd(1, 1'b1, 7'h20, 8'h00, rd);
    check("div4_rd20", rd, 8'hC3);
    check("div4_rd_cs_low", last_low, 132);
    do_cmd(2, 1'b1, 7'h20, 8'h00, rd);
    check("div8_rd20", rd, 8'hC3);
    check("div8_cs_low", last_low, 264);
    do_cmd(2, 1'b1, 7'h03, 8'h00, rd);
    check("div8_rd03", rd, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
